// File: rtl/uart_req_responder.sv
// uart_req_responder
//   Responder end of the board-to-board request/response UART link. Request
//   frames arrive byte-by-byte from the request-channel UART receiver, are
//   executed as one access on the local slave bus, and a status byte (plus
//   read data on a successful read) is returned through the response UART TX.
//
//   Frames:   write = OP, ADDR_HI, ADDR_LO, DATA     read = OP, ADDR_HI, ADDR_LO
//   Response: write -> status      read ok -> ACK, rdata      read timeout -> NAK
//
// Ports
//   clk, rst             system clock, synchronous active-high reset
//   rx_valid, rx_data    received request byte strobe and byte
//   tx_ready             response TX can accept a byte
//   tx_valid, tx_data    response byte; transfers when tx_valid && tx_ready
//   bus_req              bus request, held until bus_ack or timeout
//   bus_we               1 = write, 0 = read
//   bus_addr, bus_wdata  access address and write data
//   bus_ack, bus_rdata   slave completion strobe and read data (same cycle)
//   busy                 high whenever the FSM is not idle
//   err_count            saturating count of protocol and bus errors
module uart_req_responder #(
    parameter logic [7:0]  WR_OPCODE    = 8'h57,
    parameter logic [7:0]  RD_OPCODE    = 8'h52,
    parameter logic [7:0]  ACK_BYTE     = 8'h06,
    parameter logic [7:0]  NAK_BYTE     = 8'h15,
    parameter int unsigned BYTE_TIMEOUT = 100000,
    parameter int unsigned BUS_TIMEOUT  = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic        bus_ack,
    input  logic [7:0]  bus_rdata,
    output logic        busy,
    output logic [7:0]  err_count
);

    localparam int unsigned BT_W  = $clog2(BYTE_TIMEOUT + 1);
    localparam int unsigned BUS_W = $clog2(BUS_TIMEOUT + 1);
    localparam logic [BT_W-1:0]  BYTE_LAST = BT_W'(BYTE_TIMEOUT - 1);
    localparam logic [BUS_W-1:0] BUS_LAST  = BUS_W'(BUS_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_H,
        S_ADDR_L,
        S_DATA,
        S_BUS,
        S_RESP_ST,
        S_RESP_RD
    } state_t;

    state_t           state_q;
    logic [BT_W-1:0]  byte_tmr_q;
    logic [BUS_W-1:0] bus_tmr_q;
    logic [7:0]       rdata_q;
    logic             bus_ok_q;
    logic             tx_valid_q;
    logic [7:0]       tx_data_q;
    logic             bus_req_q;
    logic             bus_we_q;
    logic [15:0]      bus_addr_q;
    logic [7:0]       bus_wdata_q;
    logic [7:0]       err_q;
    logic [7:0]       err_d;

    logic is_opcode;
    logic byte_to;
    logic bus_to;
    logic err_event;

    assign is_opcode = (rx_data == WR_OPCODE) || (rx_data == RD_OPCODE);
    assign byte_to   = (byte_tmr_q == BYTE_LAST);
    assign bus_to    = (bus_tmr_q == BUS_LAST);

    // At most one increment per cycle even if two error sources coincide
    // (stray byte during BUS in the same cycle as the bus timeout).
    always_comb begin
        err_event = 1'b0;
        unique case (state_q)
            S_IDLE:                     err_event = rx_valid && !is_opcode;
            S_ADDR_H, S_ADDR_L, S_DATA: err_event = !rx_valid && byte_to;
            S_BUS:                      err_event = rx_valid || (!bus_ack && bus_to);
            S_RESP_ST, S_RESP_RD:       err_event = rx_valid;
            default:                    err_event = 1'b0;
        endcase
        err_d = (err_event && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            byte_tmr_q  <= '0;
            bus_tmr_q   <= '0;
            rdata_q     <= '0;
            bus_ok_q    <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            err_q       <= '0;
        end else begin
            err_q <= err_d;
            unique case (state_q)
                S_IDLE: begin
                    if (rx_valid && is_opcode) begin
                        bus_we_q   <= (rx_data == WR_OPCODE);
                        byte_tmr_q <= '0;
                        state_q    <= S_ADDR_H;
                    end
                end
                // In the byte-collecting states an arriving byte beats a
                // timeout that expires in the same cycle.
                S_ADDR_H: begin
                    if (rx_valid) begin
                        bus_addr_q[15:8] <= rx_data;
                        byte_tmr_q       <= '0;
                        state_q          <= S_ADDR_L;
                    end else if (byte_to) begin
                        state_q <= S_IDLE;
                    end else begin
                        byte_tmr_q <= byte_tmr_q + 1'b1;
                    end
                end
                S_ADDR_L: begin
                    if (rx_valid) begin
                        bus_addr_q[7:0] <= rx_data;
                        byte_tmr_q      <= '0;
                        if (bus_we_q) begin
                            state_q <= S_DATA;
                        end else begin
                            bus_req_q <= 1'b1;
                            bus_tmr_q <= '0;
                            state_q   <= S_BUS;
                        end
                    end else if (byte_to) begin
                        state_q <= S_IDLE;
                    end else begin
                        byte_tmr_q <= byte_tmr_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        bus_wdata_q <= rx_data;
                        byte_tmr_q  <= '0;
                        bus_req_q   <= 1'b1;
                        bus_tmr_q   <= '0;
                        state_q     <= S_BUS;
                    end else if (byte_to) begin
                        state_q <= S_IDLE;
                    end else begin
                        byte_tmr_q <= byte_tmr_q + 1'b1;
                    end
                end
                // bus_req is high for exactly the cycles spent here, so the
                // timeout fires after BUS_TIMEOUT request cycles.
                S_BUS: begin
                    if (bus_ack) begin
                        bus_req_q  <= 1'b0;
                        rdata_q    <= bus_rdata;
                        bus_ok_q   <= 1'b1;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= ACK_BYTE;
                        state_q    <= S_RESP_ST;
                    end else if (bus_to) begin
                        bus_req_q  <= 1'b0;
                        bus_ok_q   <= 1'b0;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= NAK_BYTE;
                        state_q    <= S_RESP_ST;
                    end else begin
                        bus_tmr_q <= bus_tmr_q + 1'b1;
                    end
                end
                S_RESP_ST: begin
                    if (tx_ready) begin
                        if (!bus_we_q && bus_ok_q) begin
                            tx_data_q <= rdata_q;
                            state_q   <= S_RESP_RD;
                        end else begin
                            tx_valid_q <= 1'b0;
                            state_q    <= S_IDLE;
                        end
                    end
                end
                S_RESP_RD: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign busy      = (state_q != S_IDLE);
    assign err_count = err_q;

endmodule
